// File: rtl/breakout_pkg.sv
// Shared colour constants, flash-state encoding and block palette helper
// for the breakout pixel renderer.
package breakout_pkg;

    localparam logic [2:0] BLACK         = 3'b000;
    localparam logic [2:0] RED           = 3'b100;
    localparam logic [2:0] GREEN         = 3'b010;
    localparam logic [2:0] WHITE         = 3'b111;
    localparam logic [2:0] BLOCK_DEFAULT = 3'b011;

    typedef enum logic [1:0] {
        FLASH_IDLE = 2'd0,
        FLASH_ON   = 2'd1,
        FLASH_OFF  = 2'd2
    } flash_state_t;

    // Block ids whose low three bits are zero would render black, so they get a fixed cyan.
    function automatic logic [2:0] block_colour(input logic [2:0] id_lo);
        return (id_lo != 3'b000) ? id_lo : BLOCK_DEFAULT;
    endfunction

endpackage

// File: rtl/breakout_pixel_renderer_flash_fsm.sv
// Win/lose flash controller: vsync falling-edge detect, frame counter and
// IDLE/ON/OFF state machine producing the 3-bit flash colour.
module flash_fsm
    import breakout_pkg::*;
#(
    parameter int FLASH_ON_FRAMES  = 3,
    parameter int FLASH_OFF_FRAMES = 3
) (
    input  logic         pxl_clk,
    input  logic         rst_n,
    input  logic         vsync,
    input  logic         win,
    input  logic         lose,
    output logic         frame_tick,
    output logic [2:0]   flash_rgb,
    output flash_state_t state_dbg
);

    localparam logic [7:0] ON_LAST  = 8'(FLASH_ON_FRAMES - 1);
    localparam logic [7:0] OFF_LAST = 8'(FLASH_OFF_FRAMES - 1);

    flash_state_t state, state_next;
    logic [7:0]   cnt, cnt_next;
    logic         vsync_q;
    logic         active;

    assign active = win | lose;

    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b1;
            frame_tick <= 1'b0;
            state      <= FLASH_IDLE;
            cnt        <= 8'd0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= vsync_q & ~vsync;
            state      <= state_next;
            cnt        <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!active) begin
            state_next = FLASH_IDLE;
            cnt_next   = 8'd0;
        end else begin
            case (state)
                FLASH_IDLE: begin
                    state_next = FLASH_ON;
                    cnt_next   = 8'd0;
                end
                FLASH_ON: begin
                    if (frame_tick) begin
                        if (cnt == ON_LAST) begin
                            state_next = FLASH_OFF;
                            cnt_next   = 8'd0;
                        end else begin
                            cnt_next = cnt + 8'd1;
                        end
                    end
                end
                FLASH_OFF: begin
                    if (frame_tick) begin
                        if (cnt == OFF_LAST) begin
                            state_next = FLASH_ON;
                            cnt_next   = 8'd0;
                        end else begin
                            cnt_next = cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state_next = FLASH_IDLE;
                    cnt_next   = 8'd0;
                end
            endcase
        end
    end

    // Colour follows the state being entered so the flash keeps the same 1-cycle latency as geometry.
    always_comb begin
        flash_rgb = BLACK;
        if (state_next == FLASH_ON) begin
            flash_rgb = win ? WHITE : RED;
        end
        state_dbg = state;
    end

endmodule

// File: rtl/breakout_pixel_renderer.sv
// Per-pixel colour generator for the breakout video path (registered RGB, 1-cycle latency).
// Define RENDER_FLASH_EN to flash the win/lose screen; otherwise it is a solid colour.
module breakout_pixel_renderer
    import breakout_pkg::*;
#(
    parameter int H_ACTIVE         = 640,
    parameter int V_ACTIVE         = 480,
    parameter int LEFT_EDGE        = 16,
    parameter int RIGHT_EDGE       = 623,
    parameter int TOP_EDGE         = 16,
    parameter int BOTTOM_EDGE      = 470,
    parameter int BALL_R           = 3,
    parameter int PLAYER_VSTART    = 440,
    parameter int PLAYER_W         = 6,
    parameter int PLAYER_HLEN      = 24,
    parameter int PLAYER_SHIFT     = 5,
    parameter int BLK_VSTART       = 40,
    parameter int BLK_VEND         = 160,
    parameter int BLK_HSTART       = 16,
    parameter int BLK_HEND         = 623,
    parameter int RGB_W            = 1,
    parameter int FLASH_ON_FRAMES  = 3,
    parameter int FLASH_OFF_FRAMES = 3
) (
    input  logic               pxl_clk,
    input  logic               rst_n,
    input  logic [9:0]         hcount,
    input  logic [9:0]         vcount,
    input  logic [9:0]         ball_x,
    input  logic [9:0]         ball_y,
    input  logic [5:0]         player_position,
    input  logic [3:0]         block_num,
    input  logic               vsync,
    input  logic               win,
    input  logic               lose,
    output logic [3*RGB_W-1:0] rgb,
    output logic               drawing_player,
    output logic               drawing_block,
    output logic               frame_tick
);

    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] LEFT_E   = 12'(LEFT_EDGE);
    localparam logic [11:0] RIGHT_E  = 12'(RIGHT_EDGE);
    localparam logic [11:0] TOP_E    = 12'(TOP_EDGE);
    localparam logic [11:0] BOT_E    = 12'(BOTTOM_EDGE);
    localparam logic [11:0] BR       = 12'(BALL_R);
    localparam logic [11:0] P_VSTART = 12'(PLAYER_VSTART);
    localparam logic [11:0] P_VEND   = 12'(PLAYER_VSTART + PLAYER_W);
    localparam logic [11:0] P_HLEN   = 12'(PLAYER_HLEN);
    localparam logic [11:0] BLK_VS   = 12'(BLK_VSTART);
    localparam logic [11:0] BLK_VE   = 12'(BLK_VEND);
    localparam logic [11:0] BLK_HS   = 12'(BLK_HSTART);
    localparam logic [11:0] BLK_HE   = 12'(BLK_HEND);

    logic [11:0] h, v, bx, by, pad_c;
    logic        blank, wall, below, ball_hit, pad_hit, blk_hit;
    logic [2:0]  flash_rgb;
    logic [2:0]  colour;
    logic        player_hit, block_hit;

    assign h     = {2'b00, hcount};
    assign v     = {2'b00, vcount};
    assign bx    = {2'b00, ball_x};
    assign by    = {2'b00, ball_y};
    assign pad_c = ({6'd0, player_position} << PLAYER_SHIFT) + LEFT_E;

    // Offsets are added to the pixel side of each compare so nothing can underflow near zero.
    assign blank    = (h >= H_ACT) || (v >= V_ACT);
    assign wall     = ((v < BOT_E) && ((h < LEFT_E) || (h > RIGHT_E))) || (v < TOP_E);
    assign below    = v > BOT_E;
    assign ball_hit = (h + BR > bx) && (bx + BR > h) && (v + BR > by) && (by + BR > v);
    assign pad_hit  = (h + P_HLEN > pad_c) && (h < pad_c + P_HLEN)
                      && (v > P_VSTART) && (v < P_VEND);
    assign blk_hit  = (block_num != 4'd0) && (v > BLK_VS) && (v <= BLK_VE)
                      && (h > BLK_HS) && (h <= BLK_HE);

`ifdef RENDER_FLASH_EN
    flash_state_t flash_state_unused;

    flash_fsm #(
        .FLASH_ON_FRAMES (FLASH_ON_FRAMES),
        .FLASH_OFF_FRAMES(FLASH_OFF_FRAMES)
    ) u_flash_fsm (
        .pxl_clk   (pxl_clk),
        .rst_n     (rst_n),
        .vsync     (vsync),
        .win       (win),
        .lose      (lose),
        .frame_tick(frame_tick),
        .flash_rgb (flash_rgb),
        .state_dbg (flash_state_unused)
    );
`else
    localparam int FLASH_PERIOD_UNUSED = FLASH_ON_FRAMES + FLASH_OFF_FRAMES;
    logic vsync_q;

    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= vsync_q & ~vsync;
        end
    end

    assign flash_rgb = win ? WHITE : RED;
`endif

    always_comb begin
        colour     = BLACK;
        player_hit = 1'b0;
        block_hit  = 1'b0;
        if (!blank) begin
            if (win | lose) begin
                colour = flash_rgb;
            end else if (wall) begin
                colour = GREEN;
            end else if (below) begin
                colour = RED;
            end else if (ball_hit) begin
                colour = WHITE;
            end else if (pad_hit) begin
                colour     = WHITE;
                player_hit = 1'b1;
            end else if (blk_hit) begin
                colour    = block_colour(block_num[2:0]);
                block_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb            <= '0;
            drawing_player <= 1'b0;
            drawing_block  <= 1'b0;
        end else begin
            rgb            <= {{RGB_W{colour[2]}}, {RGB_W{colour[1]}}, {RGB_W{colour[0]}}};
            drawing_player <= player_hit;
            drawing_block  <= block_hit;
        end
    end

endmodule

// File: tb/tb_breakout_pixel_renderer.sv
// Self-checking bench for breakout_pixel_renderer: geometry vector table, flash/reset
// sequences and randomized pixels checked against a behavioural model.
module tb_breakout_pixel_renderer;

    localparam int ON_F  = 3;
    localparam int OFF_F = 3;
    localparam logic [2:0] W = 3'b111;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] K = 3'b000;

    logic       pxl_clk;
    logic       rst_n;
    logic [9:0] hcount, vcount, ball_x, ball_y;
    logic [5:0] player_position;
    logic [3:0] block_num;
    logic       vsync, win, lose;
    logic [2:0] rgb;
    logic       drawing_player, drawing_block, frame_tick;

    int checks = 0;
    int errors = 0;

    // model state: ticks seen since flash start (-1 = not flashing), vsync history
    int k;
    bit vs_prev;
    bit tick_reg;
    logic [5:0] exp_q[$];

    typedef struct {
        int h, v, bx, by, pp, bn;
        logic [2:0] rgb;
        bit dp, db;
    } vec_t;
    vec_t tbl[$];

    logic [2:0] win_seq[8];
    logic [2:0] rel_seq[4];

    breakout_pixel_renderer dut (
        .pxl_clk        (pxl_clk),
        .rst_n          (rst_n),
        .hcount         (hcount),
        .vcount         (vcount),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .player_position(player_position),
        .block_num      (block_num),
        .vsync          (vsync),
        .win            (win),
        .lose           (lose),
        .rgb            (rgb),
        .drawing_player (drawing_player),
        .drawing_block  (drawing_block),
        .frame_tick     (frame_tick)
    );

    initial pxl_clk = 1'b0;
    always #5 pxl_clk = ~pxl_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {rgb[2:0], drawing_player, drawing_block} from the priority rules.
    function automatic logic [4:0] ref_pix(int h, int v, int bx, int by, int pp, int bn,
                                           bit act, bit flash_on, bit w);
        int c;
        c = pp * 32 + 16;
        if (h >= 640 || v >= 480) return 5'b0;
        if (act) return {flash_on ? (w ? W : R) : K, 2'b00};
        if ((v < 470 && (h < 16 || h > 623)) || v < 16) return {3'b010, 2'b00};
        if (v > 470) return {R, 2'b00};
        if (h - bx < 3 && bx - h < 3 && v - by < 3 && by - v < 3) return {W, 2'b00};
        if (h > c - 24 && h < c + 24 && v > 440 && v < 446) return {W, 2'b10};
        if (bn != 0 && v > 40 && v <= 160 && h > 16 && h <= 623)
            return {((bn % 8) != 0) ? 3'(bn % 8) : 3'b011, 2'b01};
        return 5'b0;
    endfunction

    task automatic cycle();
        logic [5:0] e;
        logic [4:0] pix;
        bit act, flash_on, new_tick;
        if (!rst_n) begin
            k = -1;
            vs_prev = 1'b1;
            tick_reg = 1'b0;
            e = 6'd0;
        end else begin
            act = win | lose;
            if (!act) k = -1;
            else if (k < 0) k = 0;
            else if (tick_reg) k++;
`ifdef RENDER_FLASH_EN
            flash_on = act && ((k % (ON_F + OFF_F)) < ON_F);
`else
            flash_on = act;
`endif
            pix = ref_pix(int'(hcount), int'(vcount), int'(ball_x), int'(ball_y),
                          int'(player_position), int'(block_num), act, flash_on, win);
            new_tick = vs_prev && !vsync;
            tick_reg = new_tick;
            vs_prev  = vsync;
            e = {pix, new_tick};
        end
        exp_q.push_back(e);
        @(posedge pxl_clk);
        #1;
        e = exp_q.pop_front();
        check("rgb", 32'(rgb), 32'(e[5:3]));
        check("drawing_player", 32'(drawing_player), 32'(e[2]));
        check("drawing_block", 32'(drawing_block), 32'(e[1]));
        check("frame_tick", 32'(frame_tick), 32'(e[0]));
    endtask

    task automatic set_pix(input int h, input int v, input int bx, input int by,
                           input int pp, input int bn);
        hcount = 10'(h);
        vcount = 10'(v);
        ball_x = 10'(bx);
        ball_y = 10'(by);
        player_position = 6'(pp);
        block_num = 4'(bn);
    endtask

    // One 10-cycle frame, vsync low on the last two cycles; flash colour checked early in the frame.
    task automatic run_frame(input string tag, input logic [2:0] exp_mid);
        for (int c = 0; c < 10; c++) begin
            vsync = (c >= 8) ? 1'b0 : 1'b1;
            cycle();
            if (c == 0 || c == 3) check(tag, 32'(rgb), 32'(exp_mid));
        end
    endtask

    task automatic add(input int h, input int v, input int bx, input int by, input int pp,
                       input int bn, input logic [2:0] c, input bit dp, input bit db);
        vec_t t;
        t.h = h; t.v = v; t.bx = bx; t.by = by; t.pp = pp; t.bn = bn;
        t.rgb = c; t.dp = dp; t.db = db;
        tbl.push_back(t);
    endtask

    initial begin
`ifdef RENDER_FLASH_EN
        win_seq = '{W, W, W, K, K, K, W, W};
        rel_seq = '{R, R, R, K};
`else
        win_seq = '{W, W, W, W, W, W, W, W};
        rel_seq = '{R, R, R, R};
`endif
        add(100, 100, 500, 300, 20, 0, K, 0, 0);
        add(0, 200, 1, 200, 20, 0, 3'b010, 0, 0);
        add(3, 200, 1, 200, 20, 0, 3'b010, 0, 0);
        add(5, 200, 1, 200, 20, 0, 3'b010, 0, 0);
        add(97, 200, 100, 200, 20, 0, K, 0, 0);
        add(98, 200, 100, 200, 20, 0, W, 0, 0);
        add(102, 200, 100, 200, 20, 0, W, 0, 0);
        add(103, 200, 100, 200, 20, 0, K, 0, 0);
        add(100, 202, 100, 200, 20, 0, W, 0, 0);
        add(100, 203, 100, 200, 20, 0, K, 0, 0);
        add(1023, 200, 1023, 200, 20, 0, K, 0, 0);
        add(120, 443, 500, 300, 4, 0, K, 0, 0);
        add(121, 443, 500, 300, 4, 0, W, 1, 0);
        add(167, 443, 500, 300, 4, 0, W, 1, 0);
        add(168, 443, 500, 300, 4, 0, K, 0, 0);
        add(144, 440, 500, 300, 4, 0, K, 0, 0);
        add(144, 441, 500, 300, 4, 0, W, 1, 0);
        add(144, 445, 500, 300, 4, 0, W, 1, 0);
        add(144, 446, 500, 300, 4, 0, K, 0, 0);
        add(16, 443, 500, 300, 0, 0, W, 1, 0);
        add(39, 443, 500, 300, 0, 0, W, 1, 0);
        add(40, 443, 500, 300, 0, 0, K, 0, 0);
        add(144, 443, 144, 443, 4, 0, W, 0, 0);
        add(300, 100, 500, 300, 20, 5, 3'b101, 0, 1);
        add(300, 100, 500, 300, 20, 8, 3'b011, 0, 1);
        add(300, 100, 500, 300, 20, 0, K, 0, 0);
        add(300, 100, 500, 300, 20, 13, 3'b101, 0, 1);
        add(300, 40, 500, 300, 20, 5, K, 0, 0);
        add(300, 41, 500, 300, 20, 5, 3'b101, 0, 1);
        add(300, 160, 500, 300, 20, 5, 3'b101, 0, 1);
        add(300, 161, 500, 300, 20, 5, K, 0, 0);
        add(17, 100, 500, 300, 20, 3, 3'b011, 0, 1);
        add(16, 100, 500, 300, 20, 3, K, 0, 0);
        add(623, 100, 500, 300, 20, 3, 3'b011, 0, 1);
        add(624, 100, 500, 300, 20, 3, 3'b010, 0, 0);
        add(640, 100, 500, 300, 20, 5, K, 0, 0);
        add(100, 480, 500, 300, 20, 0, K, 0, 0);
        add(639, 479, 500, 300, 20, 0, R, 0, 0);
        add(300, 471, 500, 300, 20, 0, R, 0, 0);
        add(300, 470, 500, 300, 20, 0, K, 0, 0);
        add(5, 470, 500, 300, 20, 0, K, 0, 0);
        add(300, 10, 500, 300, 20, 0, 3'b010, 0, 0);
        add(5, 469, 500, 300, 20, 0, 3'b010, 0, 0);

        // reset held with busy inputs: outputs must stay zero
        rst_n = 1'b0;
        set_pix(300, 100, 500, 300, 20, 5);
        win = 1'b1;
        lose = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vsync = i[0];
            cycle();
        end
        check("reset_rgb", 32'(rgb), 32'd0);
        check("reset_frame_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        win = 1'b0;
        vsync = 1'b1;

        // idle pixel after reset
        set_pix(100, 100, 500, 300, 20, 0);
        cycle();
        check("idle_black", 32'(rgb), 32'd0);

        foreach (tbl[i]) begin
            set_pix(tbl[i].h, tbl[i].v, tbl[i].bx, tbl[i].by, tbl[i].pp, tbl[i].bn);
            cycle();
            check($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(tbl[i].rgb));
            check($sformatf("vec%0d_dp", i), 32'(drawing_player), 32'(tbl[i].dp));
            check($sformatf("vec%0d_db", i), 32'(drawing_block), 32'(tbl[i].db));
        end

        // frame_tick: single pulse per falling edge
        vsync = 1'b1; cycle();
        vsync = 1'b0; cycle();
        check("tick_edge", 32'(frame_tick), 32'd1);
        cycle();
        check("tick_one_cycle", 32'(frame_tick), 32'd0);
        vsync = 1'b1; cycle();

        // win flash over eight frames
        set_pix(300, 300, 500, 300, 20, 5);
        win = 1'b1;
        for (int f = 0; f < 8; f++) run_frame($sformatf("win_frame%0d", f), win_seq[f]);
        lose = 1'b1;
        run_frame("win_lose_white", W);
        win = 1'b0;
        lose = 1'b0;
        cycle();

        // lose flash interrupted by an asynchronous reset
        lose = 1'b1;
        run_frame("lose_on", R);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb", 32'(rgb), 32'd0);
        check("async_rst_tick", 32'(frame_tick), 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int f = 0; f < 4; f++) run_frame($sformatf("release_frame%0d", f), rel_seq[f]);
        lose = 1'b0;
        cycle();

        // randomized pixels against the model
        for (int i = 0; i < 600; i++) begin
            int h, v, bx, by, pp;
            h  = int'($urandom_range(0, 700));
            v  = int'($urandom_range(0, 500));
            bx = h + int'($urandom_range(0, 8)) - 4;
            by = v + int'($urandom_range(0, 8)) - 4;
            if (bx < 0) bx = 0;
            if (by < 0) by = 0;
            pp = int'($urandom_range(0, 63));
            if ($urandom_range(0, 2) == 0) begin
                v  = int'($urandom_range(439, 447));
                pp = (h > 16) ? ((h - 16) / 32) % 64 : 0;
                if ($urandom_range(0, 1) == 0) bx = 900;
            end
            set_pix(h, v, bx, by, pp, int'($urandom_range(0, 15)));
            win   = ($urandom_range(0, 15) == 0);
            lose  = ($urandom_range(0, 15) == 0);
            vsync = ((i % 20) >= 17) ? 1'b0 : 1'b1;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/breakout_pixel_renderer.md
# breakout_pixel_renderer

Parametrised per-pixel colour generator for the breakout video path. It sits between the VGA timing generator (`hcount`/`vcount`/`vsync`) and the DAC pins. It decodes playfield, ball, paddle and block geometry into a registered RGB word with 1-cycle latency. A frame-counted flash state machine drives the win/lose screen, and `drawing_player`/`drawing_block` qualifiers go to the collision logic.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible columns; `hcount >= H_ACTIVE` is blanking.
- `V_ACTIVE`, 480: visible rows.
- `LEFT_EDGE`, 16 / `RIGHT_EDGE`, 623 / `TOP_EDGE`, 16 / `BOTTOM_EDGE`, 470: playfield walls.
- `BALL_R`, 3: ball half-size; a pixel is ball when `|h-x| < BALL_R` and `|v-y| < BALL_R`.
- `PLAYER_VSTART`, 440 / `PLAYER_W`, 6 / `PLAYER_HLEN`, 24 / `PLAYER_SHIFT`, 5: paddle geometry; centre = `(player_position << PLAYER_SHIFT) + LEFT_EDGE`.
- `BLK_VSTART`, 40 / `BLK_VEND`, 160 / `BLK_HSTART`, 16 / `BLK_HEND`, 623: block field, start-exclusive and end-inclusive.
- `RGB_W`, 1: bits per colour channel.
- `FLASH_ON_FRAMES`, 3 / `FLASH_OFF_FRAMES`, 3: flash phase lengths, each ≥1.

Ports:
- `pxl_clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `hcount`, `vcount` in 10: current pixel.
- `ball_x`, `ball_y` in 10: ball centre.
- `player_position` in 6: paddle slot.
- `block_num` in 4: block id at the current pixel; 0 means no block.
- `vsync` in 1: active-low sync.
- `win`, `lose` in 1: game result levels.
- `rgb` out `3*RGB_W`: registered colour, channel order {R,G,B}.
- `drawing_player`, `drawing_block` out 1: registered, aligned with `rgb`.
- `frame_tick` out 1: registered one-cycle pulse on each `vsync` falling edge.

## Operation
- Colour priority, highest first:
  1. Blanking: black.
  2. `win|lose`: the flash colour.
  3. Wall: green. A wall pixel is `v < BOTTOM_EDGE` with `h < LEFT_EDGE` or `h > RIGHT_EDGE`, or `v < TOP_EDGE`.
  4. `v > BOTTOM_EDGE`: red.
  5. Ball: white.
  6. Paddle, strict inequalities: white, and `drawing_player` = 1.
  7. Block (`block_num != 0` and inside the block field): `drawing_block` = 1. Colour = `block_num[2:0]` when that value is non-zero, otherwise 3'b011.
  8. Otherwise black.
- Each 1-bit colour is widened to `RGB_W` by replicating the bit in every channel.
- Ball and paddle comparisons use 12-bit unsigned-safe arithmetic. Compare `h + BALL_R > x` rather than `h > x - BALL_R`. No wrap-around occurs when `ball_x < BALL_R` or when the paddle centre is below `PLAYER_HLEN`.
- Flash FSM states: IDLE, ON, OFF.
  - IDLE→ON when `win|lose` is high; the frame counter clears.
  - ON→OFF after `FLASH_ON_FRAMES` frame ticks.
  - OFF→ON after `FLASH_OFF_FRAMES` frame ticks.
  - Any state→IDLE on the cycle `win|lose` is low.
- Flash colour:
  - ON: white when `win`, red when `lose` only. `win` has priority when both are high.
  - OFF and IDLE: black.

## Timing
- Output latency is 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- `frame_tick` is asserted the cycle after `vsync` is sampled 1 following a sample of 1→0. The previous-`vsync` register resets to 1.
- The FSM advances on `frame_tick`. It enters ON one cycle after `win|lose` is first sampled high, mid-frame included.
- Reset values: `rgb` = 0, `drawing_*` = 0, `frame_tick` = 0, state IDLE, frame counter 0.
- Reset asserted mid-flash forces IDLE immediately and asynchronously. After release, ON is re-entered on the first edge with `win|lose` high.

## Configuration
- `RENDER_FLASH_EN` defined: FSM behaviour as above.
- `RENDER_FLASH_EN` undefined:
  - No FSM or frame counter.
  - `win` gives solid white; `lose` gives solid red.
  - `frame_tick` is still generated.

## Structure
- Package `breakout_pkg`: colour constants (`BLACK`, `RED`, `GREEN`, `WHITE`, 3-bit) and the flash-state enum.
- Sub-module `flash_fsm`: owns the `vsync` edge detect, frame counter, state and flash colour. It is instantiated only under `RENDER_FLASH_EN`.

## Test plan
- Reset, then h=100, v=100, all objects away → next cycle `rgb` = 0. Also hold `rst_n` low: all outputs stay 0.
- `ball_x` = 1, `ball_y` = 200; sweep h = 0..5 at v = 200 → white at h = 0..3 after wall priority, i.e. green at h < 16. Then `ball_x` = 100: white exactly h = 98..102. No stray white near h = 1023.
- `player_position` = 4 (centre 144), v = 443 → white with `drawing_player` = 1 for h = 121..167; h = 120 and 168 are black.
- v = 100, h = 300: `block_num` = 5 → `rgb` 3'b101, `drawing_block` = 1; `block_num` = 8 → 3'b011; `block_num` = 0 → black, `drawing_block` = 0.
- `win` = 1 with 8 vsync pulses and ON=OFF=3 → `rgb` sequence per frame W,W,W,K,K,K,W,W. `win` = `lose` = 1 → white in ON phases.
- `lose` = 1, reset pulsed during ON → `rgb` = 0 at once. After release, red from the next cycle and for 3 frames.
